// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - triangle FIFO and issue scheduler feeding the rasterizer
module raster_scheduler #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 24,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [9*COORD_W-1:0]   in_tri,
    input  logic [COLOR_W-1:0]     in_color,
    input  logic                   frame_end,
    output logic                   r_start,
    output logic [9*COORD_W-1:0]   r_tri,
    output logic [COLOR_W-1:0]     r_color,
    output logic                   r_tri_ready,
    input  logic                   r_tri_read,
    input  logic                   r_done,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CNT_W-1:0]       frame_count,
    output logic                   err
);
    localparam int TRI_W = 9 * COORD_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state;
    logic [TRI_W-1:0]   tri_mem   [DEPTH];
    logic [COLOR_W-1:0] color_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [WD_W-1:0]    wdog;
    logic [CNT_W-1:0]   tri_cnt;
    logic               pend;
    logic               push;
    logic               pop;
    logic               empty;
    logic               frame_close;

    // Full blocks a push even when the head is popped in the same cycle.
    assign in_ready    = (count != FULL_CNT);
    assign empty       = (count == '0);
    assign push        = in_valid && in_ready;
    assign pop         = (state == ISSUE) && r_tri_read;
    assign busy        = (state != IDLE) || !empty;
    // A push this cycle still belongs to the pending frame, so it holds the close off.
    assign frame_close = pend && (state == IDLE) && empty && !push;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            tri_mem[wr_ptr]   <= in_tri;
            color_mem[wr_ptr] <= in_color;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: load head in IDLE, offer it in ISSUE, wait for done or watchdog in RUN.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state       <= IDLE;
            r_start     <= 1'b0;
            r_tri_ready <= 1'b0;
            r_tri       <= '0;
            r_color     <= '0;
            wdog        <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        r_tri       <= tri_mem[rd_ptr];
                        r_color     <= color_mem[rd_ptr];
                        r_start     <= 1'b1;
                        r_tri_ready <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    if (r_tri_read) begin
                        r_tri_ready <= 1'b0;
                        wdog        <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (r_done) begin
                        state <= IDLE;
                    end else if (wdog == WDOG_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    r_start     <= 1'b0;
                    r_tri_ready <= 1'b0;
                end
            endcase
        end
    end

    // Frame bookkeeping: count completed jobs, close the frame once the pipe drains.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            pend        <= 1'b0;
            tri_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (frame_close) begin
                frame_done  <= 1'b1;
                frame_count <= tri_cnt;
                tri_cnt     <= '0;
                pend        <= 1'b0;
            end else begin
                if (frame_end) pend <= 1'b1;
                if ((state == RUN) && r_done) tri_cnt <= tri_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raster_scheduler.sv
// tb/tb_raster_scheduler.sv - self-checking bench for raster_scheduler
module tb_raster_scheduler;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 24;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int TRI_W   = 9 * COORD_W;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               in_valid;
    logic               in_ready;
    logic [TRI_W-1:0]   in_tri;
    logic [COLOR_W-1:0] in_color;
    logic               frame_end;
    logic               r_start;
    logic [TRI_W-1:0]   r_tri;
    logic [COLOR_W-1:0] r_color;
    logic               r_tri_ready;
    logic               r_tri_read;
    logic               r_done;
    logic               busy;
    logic               frame_done;
    logic [CNT_W-1:0]   frame_count;
    logic               err;

    raster_scheduler #(
        .COORD_W(COORD_W), .COLOR_W(COLOR_W), .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_tri(in_tri), .in_color(in_color), .frame_end(frame_end),
        .r_start(r_start), .r_tri(r_tri), .r_color(r_color),
        .r_tri_ready(r_tri_ready), .r_tri_read(r_tri_read), .r_done(r_done),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;
    int fd0;
    int n;
    int pushed, served, phase, wait_cnt, done_cnt, cyc;
    logic [TRI_W-1:0]   tv [8];
    logic [COLOR_W-1:0] cv [8];
    logic [TRI_W-1:0]   exp_tri [$];
    logic [COLOR_W-1:0] exp_col [$];
    logic [TRI_W-1:0]   et;
    logic [COLOR_W-1:0] ec;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    function automatic logic [TRI_W-1:0] rnd_tri();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        return w[TRI_W-1:0];
    endfunction

    function automatic logic [COLOR_W-1:0] rnd_col();
        logic [31:0] w;
        w = $urandom();
        return w[COLOR_W-1:0];
    endfunction

    task automatic do_reset();
        n_rst = 1'b1; in_valid = 1'b0; r_tri_read = 1'b0; r_done = 1'b0; frame_end = 1'b0;
        tick();
        n_rst = 1'b0;
    endtask

    task automatic push(input logic [TRI_W-1:0] t, input logic [COLOR_W-1:0] c);
        int k = 0;
        while (in_ready !== 1'b1 && k < 100) begin tick(); k++; end
        check("push_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_tri = t; in_color = c;
        tick();
        in_valid = 1'b0;
    endtask

    // Rasterizer model: accept after rd cycles of tri_ready, finish dd cycles after accept.
    task automatic serve(input string tag, input int rd, input int dd,
                         input logic [TRI_W-1:0] t, input logic [COLOR_W-1:0] c, input bit give_done);
        int k = 0;
        while (r_tri_ready !== 1'b1 && k < 200) begin tick(); k++; end
        check({tag, "_ready"}, 128'(r_tri_ready), 128'(1));
        repeat (rd) tick();
        check({tag, "_tri"}, 128'(r_tri), 128'(t));
        check({tag, "_color"}, 128'(r_color), 128'(c));
        r_tri_read = 1'b1;
        tick();
        r_tri_read = 1'b0;
        if (give_done) begin
            repeat (dd) tick();
            r_done = 1'b1;
            tick();
            r_done = 1'b0;
        end
    endtask

    task automatic wait_frame_done();
        int k = 0;
        while (frame_done !== 1'b1 && k < 100) begin tick(); k++; end
        check("frame_done_seen", 128'(frame_done), 128'(1));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin tv[i] = rnd_tri(); cv[i] = rnd_col(); end
        in_tri = '0; in_color = '0;

        // Reset values
        do_reset();
        n_rst = 1'b1;
        tick();
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_r_start", 128'(r_start), 128'(0));
        check("rst_r_tri_ready", 128'(r_tri_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_frame_count", 128'(frame_count), 128'(0));
        n_rst = 1'b0;

        // 1: single triangle
        do_reset();
        push(tv[0], cv[0]);
        check("t1_not_yet_offered", 128'(r_tri_ready), 128'(0));
        tick();
        check("t1_tri_ready", 128'(r_tri_ready), 128'(1));
        check("t1_start", 128'(r_start), 128'(1));
        check("t1_tri", 128'(r_tri), 128'(tv[0]));
        check("t1_color", 128'(r_color), 128'(cv[0]));
        tick();
        check("t1_start_pulse", 128'(r_start), 128'(0));
        check("t1_tri_stable", 128'(r_tri), 128'(tv[0]));
        tick();
        r_tri_read = 1'b1;
        tick();
        r_tri_read = 1'b0;
        check("t1_ready_drop", 128'(r_tri_ready), 128'(0));
        check("t1_busy_run", 128'(busy), 128'(1));
        repeat (9) tick();
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        check("t1_busy_after_done", 128'(busy), 128'(0));

        // 2: fill with stalled rasterizer
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_tri = tv[i]; in_color = cv[i];
            check("t2_fill_ready", 128'(in_ready), 128'(1));
            tick();
        end
        check("t2_full", 128'(in_ready), 128'(0));
        in_tri = rnd_tri(); in_color = rnd_col();
        tick();
        check("t2_ninth_blocked", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        check("t2_head_tri", 128'(r_tri), 128'(tv[0]));
        check("t2_head_offered", 128'(r_tri_ready), 128'(1));
        r_tri_read = 1'b1;
        tick();
        r_tri_read = 1'b0;
        check("t2_ready_after_pop", 128'(in_ready), 128'(1));
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        for (int i = 1; i < 8; i++) serve("t2_drain", 0, 0, tv[i], cv[i], 1'b1);
        check("t2_drained", 128'(busy), 128'(0));

        // 3: frame accounting
        do_reset();
        fd0 = fd_seen;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin in_tri = tv[i]; in_color = cv[i]; tick(); end
        in_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        tick();
        frame_end = 1'b0;
        serve("t3_a", 2, 3, tv[0], cv[0], 1'b1);
        serve("t3_b", 1, 0, tv[1], cv[1], 1'b1);
        check("t3_no_early_done", 128'(fd_seen - fd0), 128'(0));
        serve("t3_c", 0, 5, tv[2], cv[2], 1'b1);
        tick();
        tick();
        check("t3_one_frame_done", 128'(fd_seen - fd0), 128'(1));
        check("t3_frame_count", 128'(frame_count), 128'(3));
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("t3_empty_not_yet", 128'(frame_done), 128'(0));
        tick();
        check("t3_empty_frame_done", 128'(frame_done), 128'(1));
        check("t3_empty_count", 128'(frame_count), 128'(0));

        // 4: watchdog
        do_reset();
        push(tv[3], cv[3]);
        push(tv[4], cv[4]);
        serve("t4_hung", 0, 0, tv[3], cv[3], 1'b0);
        repeat (15) tick();
        check("t4_err_before", 128'(err), 128'(0));
        tick();
        check("t4_err_at_timeout", 128'(err), 128'(1));
        serve("t4_next", 0, 2, tv[4], cv[4], 1'b1);
        check("t4_err_sticky", 128'(err), 128'(1));
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        wait_frame_done();
        check("t4_count_excludes_drop", 128'(frame_count), 128'(1));

        // 5: reset while running with 4 queued
        for (int i = 0; i < 5; i++) push(tv[i], cv[i]);
        serve("t5_run", 0, 0, tv[0], cv[0], 1'b0);
        fd0 = fd_seen;
        n_rst = 1'b1;
        tick();
        check("t5_in_ready", 128'(in_ready), 128'(1));
        check("t5_r_start", 128'(r_start), 128'(0));
        check("t5_r_tri_ready", 128'(r_tri_ready), 128'(0));
        check("t5_r_tri", 128'(r_tri), 128'(0));
        check("t5_r_color", 128'(r_color), 128'(0));
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_frame_count", 128'(frame_count), 128'(0));
        check("t5_err", 128'(err), 128'(0));
        n_rst = 1'b0;
        repeat (5) tick();
        check("t5_queue_dropped", 128'(busy), 128'(0));
        check("t5_no_frame_done", 128'(fd_seen - fd0), 128'(0));

        // 6: random ordering against a queue model
        do_reset();
        pushed = 0; served = 0; phase = 0; cyc = 0;
        wait_cnt = $urandom_range(0, 7);
        done_cnt = 0;
        while (served < 20 && cyc < 3000) begin
            r_tri_read = 1'b0; r_done = 1'b0; in_valid = 1'b0;
            if (phase == 0) begin
                if (r_tri_ready === 1'b1) begin
                    if (wait_cnt == 0) begin
                        if (exp_tri.size() == 0) begin
                            check("t6_unexpected_issue", 128'(r_tri_ready), 128'(0));
                        end else begin
                            et = exp_tri.pop_front();
                            ec = exp_col.pop_front();
                            check("t6_order_tri", 128'(r_tri), 128'(et));
                            check("t6_order_color", 128'(r_color), 128'(ec));
                        end
                        r_tri_read = 1'b1;
                        phase = 1;
                        done_cnt = $urandom_range(0, 7);
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                if (done_cnt == 0) begin
                    r_done = 1'b1;
                    phase = 0;
                    served++;
                    wait_cnt = $urandom_range(0, 7);
                end else begin
                    done_cnt--;
                end
            end
            if (pushed < 20 && in_ready === 1'b1 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_tri = rnd_tri();
                in_color = rnd_col();
                exp_tri.push_back(in_tri);
                exp_col.push_back(in_color);
                pushed++;
            end
            tick();
            cyc++;
        end
        r_tri_read = 1'b0; r_done = 1'b0; in_valid = 1'b0;
        check("t6_all_served", 128'(served), 128'(20));
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        wait_frame_done();
        check("t6_frame_count", 128'(frame_count), 128'(20));
        check("t6_err_clear", 128'(err), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
